// File: rtl/memory_controller_interface.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : memory_controller_interface                                  |
// | Description : Shared request/response types for the memory-controller     |
// |               interface (MCI) used by the caches and the arbiter.          |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package memory_controller_interface;

  localparam int MCI_DATA_LENGTH = 32;
  localparam int MCI_ADDR_LENGTH = 32;

  // valid is a single-cycle pulse; rw = 1 is a write.
  typedef struct packed {
    logic [MCI_ADDR_LENGTH-1:0] addr;
    logic [MCI_DATA_LENGTH-1:0] data;
    logic                       rw;
    logic                       valid;
  } mci_request_t;

  // ready is a single-cycle pulse marking completion; data is read data.
  typedef struct packed {
    logic [MCI_DATA_LENGTH-1:0] data;
    logic                       ready;
  } mci_response_t;

endpackage : memory_controller_interface
`default_nettype wire

// File: rtl/mci_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mci_arbiter                                                  |
// | Description : Two-port arbiter sharing one memory controller between the   |
// |               instruction cache (port 0) and data cache (port 1). Each     |
// |               port owns a one-deep pending slot; one transaction is        |
// |               outstanding at a time.                                       |
// | Ports       : clk         single clock                                     |
// |               rst         synchronous active-high reset                    |
// |               i_req/i_res icache request in / response out                 |
// |               d_req/d_res dcache request in / response out                 |
// |               mem_req     request to the memory controller                 |
// |               mem_res     response from the memory controller              |
// |               busy        a memory transaction is outstanding              |
// |               owner       port of the current or last grant (0=i, 1=d)     |
// |               err_overrun sticky: a request pulse was dropped              |
// | Parameter   : FIXED_PRI_PORT  tie winner (fixed mode) / first tie winner   |
// |                               after reset (round-robin mode)             |
// | Macro       : MCI_ARB_ROUND_ROBIN_EN  defined -> round-robin tie-break,    |
// |               undefined -> FIXED_PRI_PORT always wins ties                 |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module mci_arbiter
  import memory_controller_interface::*;
#(
  parameter int FIXED_PRI_PORT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  mci_request_t  i_req,
  output mci_response_t i_res,
  input  mci_request_t  d_req,
  output mci_response_t d_res,
  output mci_request_t  mem_req,
  input  mci_response_t mem_res,
  output logic          busy,
  output logic          owner,
  output logic          err_overrun
);

  localparam logic c_pri_port = (FIXED_PRI_PORT != 0);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Pending slots; the valid field doubles as the "slot full" flag.
  mci_request_t r_i_slot;
  mci_request_t r_d_slot;

  // Granted request, held on mem_req for the whole BUSY phase.
  logic [MCI_ADDR_LENGTH-1:0] r_hold_addr;
  logic [MCI_DATA_LENGTH-1:0] r_hold_data;
  logic                       r_hold_rw;

  logic r_owner;
  logic r_err;

  logic w_grant;       // IDLE cycle issuing a slot to memory
  logic w_grant_port;  // which slot is issued
  logic w_done;        // BUSY cycle in which memory completes
  logic w_tie_port;    // winner when both slots are pending

  logic w_i_own_busy;
  logic w_d_own_busy;
  logic w_i_accept;
  logic w_d_accept;
  logic w_i_drop;
  logic w_d_drop;

`ifdef MCI_ARB_ROUND_ROBIN_EN
  // Set by the first grant after reset; until then ties go to the
  // configured port instead of "the port not granted last".
  logic r_granted_any;

  always_comb begin
    w_tie_port = r_granted_any ? ~r_owner : c_pri_port;
  end
`else
  always_comb begin
    w_tie_port = c_pri_port;
  end
`endif

  // --------------------------------------------------------------------------
  // Request acceptance. A port is blocked while its slot is full or while its
  // own transaction is outstanding, except in the completion cycle, so that a
  // writeback can be chained with the following allocate read. A pulse in the
  // cycle its slot is being granted sees the slot still full and is dropped.
  // --------------------------------------------------------------------------
  always_comb begin
    w_i_own_busy = (r_state == ST_BUSY) && (r_owner == 1'b0) && !w_done;
    w_d_own_busy = (r_state == ST_BUSY) && (r_owner == 1'b1) && !w_done;
    w_i_accept   = i_req.valid && !rst && !r_i_slot.valid && !w_i_own_busy;
    w_d_accept   = d_req.valid && !rst && !r_d_slot.valid && !w_d_own_busy;
    w_i_drop     = i_req.valid && !rst && !w_i_accept;
    w_d_drop     = d_req.valid && !rst && !w_d_accept;
  end

  // --------------------------------------------------------------------------
  // FSM next-state and outputs.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_grant      = 1'b0;
    w_grant_port = r_owner;
    w_done       = 1'b0;

    mem_req.addr  = r_hold_addr;
    mem_req.data  = r_hold_data;
    mem_req.rw    = r_hold_rw;
    mem_req.valid = 1'b0;

    // Read data is broadcast to both caches; only ready is steered.
    i_res.data  = mem_res.data;
    i_res.ready = 1'b0;
    d_res.data  = mem_res.data;
    d_res.ready = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // mem_res.ready is deliberately ignored here: it can only belong to
        // a transaction abandoned by reset.
        if (!rst && (r_i_slot.valid || r_d_slot.valid)) begin
          w_grant = 1'b1;
          if (r_i_slot.valid && r_d_slot.valid) begin
            w_grant_port = w_tie_port;
          end else begin
            w_grant_port = r_d_slot.valid;
          end

          if (w_grant_port) begin
            mem_req.addr = r_d_slot.addr;
            mem_req.data = r_d_slot.data;
            mem_req.rw   = r_d_slot.rw;
          end else begin
            mem_req.addr = r_i_slot.addr;
            mem_req.data = r_i_slot.data;
            mem_req.rw   = r_i_slot.rw;
          end
          mem_req.valid = 1'b1;
          w_state_nxt   = ST_BUSY;
        end
      end

      ST_BUSY: begin
        if (mem_res.ready && !rst) begin
          w_done      = 1'b1;
          i_res.ready = (r_owner == 1'b0);
          d_res.ready = (r_owner == 1'b1);
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM state, owner, held request and sticky error.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_owner     <= c_pri_port;
      r_hold_addr <= '0;
      r_hold_data <= '0;
      r_hold_rw   <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_owner     <= w_grant_port;
        r_hold_addr <= mem_req.addr;
        r_hold_data <= mem_req.data;
        r_hold_rw   <= mem_req.rw;
      end
      if (w_i_drop || w_d_drop) begin
        r_err <= 1'b1;
      end
    end
  end

`ifdef MCI_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_granted_any <= 1'b0;
    end else if (w_grant) begin
      r_granted_any <= 1'b1;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Pending slots. Accept and grant never hit the same slot in one cycle:
  // accept needs the slot empty, grant needs it full.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_i_slot <= '0;
      r_d_slot <= '0;
    end else begin
      if (w_grant && !w_grant_port) begin
        r_i_slot.valid <= 1'b0;
      end
      if (w_grant && w_grant_port) begin
        r_d_slot.valid <= 1'b0;
      end
      if (w_i_accept) begin
        r_i_slot <= '{addr: i_req.addr, data: i_req.data, rw: i_req.rw, valid: 1'b1};
      end
      if (w_d_accept) begin
        r_d_slot <= '{addr: d_req.addr, data: d_req.data, rw: d_req.rw, valid: 1'b1};
      end
    end
  end

  assign busy        = (r_state == ST_BUSY);
  assign owner       = r_owner;
  assign err_overrun = r_err;

endmodule : mci_arbiter
`default_nettype wire

// File: doc/mci_arbiter.md
MCI_ARBITER -- requirements
Module: mci_arbiter

Interface
REQ-001 SHALL have parameter FIXED_PRI_PORT, default 1, meaning winning port on simultaneous pending requests (0 = icache, 1 = dcache) in fixed mode, and first grant after reset in round-robin mode.
REQ-002 SHALL have port clk  input  1  the single clock.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port i_req  input  mci_request_t  icache request {addr, data, rw, valid}.
REQ-005 SHALL have port i_res  output  mci_response_t  icache response {data, ready}.
REQ-006 SHALL have port d_req  input  mci_request_t  dcache request.
REQ-007 SHALL have port d_res  output  mci_response_t  dcache response.
REQ-008 SHALL have port mem_req  output  mci_request_t  request to the memory controller.
REQ-009 SHALL have port mem_res  input  mci_response_t  memory controller response.
REQ-010 SHALL have port busy  output  1  high while a memory transaction is outstanding.
REQ-011 SHALL have port owner  output  1  port of the current or last grant (0 = icache, 1 = dcache).
REQ-012 SHALL have port err_overrun  output  1  sticky protocol-violation flag.
REQ-013 SHALL take all types and MCI_DATA_LENGTH from package memory_controller_interface.

Function
REQ-014 SHALL treat req.valid as a one-cycle pulse and latch addr, data and rw into a per-port pending slot in the cycle valid is high.
REQ-015 SHALL hold at most one pending request per port; valid on a port whose slot is full or whose transaction is outstanding SHALL be dropped and SHALL set err_overrun.
REQ-016 SHALL implement FSM states IDLE and BUSY.
REQ-017 IDLE: if any slot is pending, SHALL select one per arbitration policy, drive mem_req with its fields and mem_req.valid=1 for exactly that cycle, clear the slot, record owner, go to BUSY.
REQ-018 IDLE with no pending slot: mem_req.valid=0, stay IDLE.
REQ-019 BUSY: mem_req.valid=0; on mem_res.ready SHALL pulse ready on the owner's response port only in that same cycle and return to IDLE.
REQ-020 i_res.data and d_res.data SHALL equal mem_res.data combinationally at all times; ready SHALL be 0 on the non-owner port and in IDLE.
REQ-021 Minimum latency: request pulse in cycle N -> mem_req.valid in cycle N+1.
REQ-022 A valid pulse from the owner in the same cycle as its ready SHALL be accepted (writeback-then-allocate sequence) and be eligible in the following IDLE cycle.
REQ-023 mem_res.ready in IDLE SHALL be ignored.
REQ-024 mem_req.addr, data, rw SHALL hold the granted request's values throughout BUSY.
REQ-025 A request arriving on a port in the same cycle as that port is granted from IDLE is impossible by REQ-015 (slot or transaction in use) and SHALL be dropped with err_overrun.

Reset
REQ-026 On rst high at clk edge: state IDLE, both slots empty, owner=FIXED_PRI_PORT, err_overrun=0, busy=0, mem_req.valid=0, all response ready=0.
REQ-027 Reset during BUSY SHALL abandon the outstanding transaction; a later mem_res.ready SHALL be ignored per REQ-023.
REQ-028 Valid pulses in a cycle where rst is high SHALL be discarded.

Configuration
REQ-029 Macro MCI_ARB_ROUND_ROBIN_EN defined: on simultaneous pending, the port not granted last SHALL win; first tie after reset goes to FIXED_PRI_PORT.
REQ-030 Macro MCI_ARB_ROUND_ROBIN_EN undefined: on simultaneous pending, FIXED_PRI_PORT SHALL always win.

Verification
REQ-031 d_req read pulse at addr 0x0000_1230 in cycle 5, mem ready in cycle 9 -> mem_req.valid only in cycle 6 with that addr; d_res.ready only in cycle 9; i_res.ready never high.
REQ-032 i_req and d_req pulse in the same cycle, fixed mode, FIXED_PRI_PORT=1 -> dcache issued first, icache issued in the IDLE cycle after dcache's ready; with round robin and last owner=1 -> icache first.
REQ-033 dcache writeback (rw=1) completes with ready in cycle 10 while d_req read pulses in cycle 10 -> read issued cycle 11, err_overrun stays 0.
REQ-034 d_req pulses twice while its first request is BUSY -> second dropped, err_overrun=1 until rst.
REQ-035 rst asserted during BUSY, mem_res.ready arrives 2 cycles after rst deasserts -> no response ready pulses, busy=0, mem_req.valid stays 0.
